alu_issue: RTL and testbench

//  Decode/issue stage feeding the hart ALU. Accepts a fetched instruction plus PC and reads rs1/rs2

---
 rtl/alu_issue.sv | 102 ++++++++++
 tb/tb_alu_issue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage building ALU operands with bypass and a handshaked output register
module alu_issue #(
  parameter int XLEN      = 64,
  parameter bit RESET_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [14:0]     out_op_ir,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]      opc;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, imm_u, imm_z, a, b;
  logic [4:0]      rd;
  logic            illegal, accept;

  assign opc      = in_ir[6:0];
  assign rs1_addr = in_ir[19:15];
  assign rs2_addr = in_ir[24:20];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // x0 reads zero; a same-cycle writeback to the source register wins over the regfile
  assign rs1_val = (rs1_addr == 5'd0) ? '0 : (wb_en && wb_rd == rs1_addr) ? wb_data : rs1_data;
  assign rs2_val = (rs2_addr == 5'd0) ? '0 : (wb_en && wb_rd == rs2_addr) ? wb_data : rs2_data;

  assign imm_i = {{(XLEN-12){in_ir[31]}}, in_ir[31:20]};
  assign imm_s = {{(XLEN-12){in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
  assign imm_u = {{(XLEN-32){in_ir[31]}}, in_ir[31:12], 12'b0};
  assign imm_z = {{(XLEN-5){1'b0}}, in_ir[19:15]};
  assign rd    = (opc == OP_STORE || opc == OP_BRANCH) ? 5'd0 : in_ir[11:7];

  // operand selection by opcode; unknown opcodes issue as illegal with zero operands
  always_comb begin
    a = '0;
    b = '0;
    illegal = 1'b0;
    case (opc)
      OP_OP, OP_OP32, OP_AMO, OP_BRANCH: begin a = rs1_val; b = rs2_val; end
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR: begin a = rs1_val; b = imm_i; end
      OP_STORE:  begin a = rs1_val; b = imm_s; end
      OP_LUI:    b = imm_u;
      OP_AUIPC:  begin a = in_pc; b = imm_u; end
      OP_JAL:    a = in_pc;
      OP_SYSTEM: begin a = rs1_val; b = in_ir[14] ? imm_z : rs2_val; end
      default:   illegal = 1'b1;
    endcase
  end

  // output register: flush kills, accept loads, drain clears valid, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_op_ir   <= RESET_NOP ? 15'h0013 : 15'h0000;
      out_rd      <= 5'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_a       <= a;
      out_b       <= b;
      out_op_ir   <= {in_ir[31:27], in_ir[14:12], in_ir[6:0]};
      out_rd      <= rd;
      out_illegal <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a behavioural model
module tb_alu_issue;
  logic        clk, rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_ir;
  logic [63:0] in_pc, rs1_data, rs2_data, wb_data, out_a, out_b;
  logic [4:0]  rs1_addr, rs2_addr, wb_rd, out_rd;
  logic [14:0] out_op_ir;

  int checks, failures;

  logic        exp_valid, exp_ill;
  logic [63:0] exp_a, exp_b;
  logic [14:0] exp_op;
  logic [4:0]  exp_rd;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_op_ir(out_op_ir), .out_rd(out_rd),
    .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] src(input logic [4:0] r, input logic [63:0] d);
    if (r == 5'd0) return 64'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return d;
  endfunction

  task automatic decode(input logic [31:0] ir, input logic [63:0] pc, r1, r2,
                        output logic [63:0] a, b, output logic ill, output logic [4:0] rd);
    logic [63:0] ii, is, iu, iz;
    ii = 64'($signed(ir[31:20]));
    is = 64'($signed({ir[31:25], ir[11:7]}));
    iu = 64'($signed({ir[31:12], 12'h000}));
    iz = 64'(ir[19:15]);
    a = 0; b = 0; ill = 0;
    case (ir[6:0])
      7'h33, 7'h3B, 7'h2F, 7'h63: begin a = r1; b = r2; end
      7'h13, 7'h1B, 7'h03, 7'h67: begin a = r1; b = ii; end
      7'h23: begin a = r1; b = is; end
      7'h37: b = iu;
      7'h17: begin a = pc; b = iu; end
      7'h6F: a = pc;
      7'h73: begin a = r1; b = ir[14] ? iz : r2; end
      default: ill = 1;
    endcase
    rd = (ir[6:0] == 7'h23 || ir[6:0] == 7'h63) ? 5'd0 : ir[11:7];
  endtask

  task automatic tick();
    logic [63:0] a, b;
    logic        ill, acc;
    logic [4:0]  rd;
    decode(in_ir, in_pc, src(in_ir[19:15], rs1_data), src(in_ir[24:20], rs2_data), a, b, ill, rd);
    acc = in_valid && (!exp_valid || out_ready) && !flush;
    @(posedge clk);
    #1;
    if (flush) exp_valid = 0;
    else if (acc) begin
      exp_valid = 1; exp_a = a; exp_b = b; exp_ill = ill; exp_rd = rd;
      exp_op = {in_ir[31:27], in_ir[14:12], in_ir[6:0]};
    end else if (out_ready) exp_valid = 0;
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_a = 0; exp_b = 0; exp_op = 15'h0013; exp_rd = 0; exp_ill = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_ir = 32'h0000_0013; in_pc = 64'h1000; rs1_data = 0; rs2_data = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_a !== 64'd0 || out_b !== 64'd0 || out_op_ir !== 15'h0013 ||
        out_rd !== 5'd0 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: valid=%b a=%h b=%h op=%h rd=%0d ill=%b rdy=%b, required 0 0 0 0013 0 0 1",
               out_valid, out_a, out_b, out_op_ir, out_rd, out_illegal, in_ready);
    end
  endtask

  task automatic test_directed();
    in_valid = 1; out_ready = 1;
    in_ir = 32'hFFD08293; rs1_data = 7;
    #1;
    checks++;
    if (rs1_addr !== 5'd1 || rs2_addr !== 5'd29) begin
      failures++; $display("FAIL addr: rs1=%0d rs2=%0d required 1 29", rs1_addr, rs2_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1 || out_a !== 64'd7 || out_b !== 64'hFFFF_FFFF_FFFF_FFFD || out_op_ir !== 15'h7C13 || out_rd !== 5'd5) begin
      failures++; $display("FAIL addi: v=%b a=%h b=%h op=%h rd=%0d", out_valid, out_a, out_b, out_op_ir, out_rd);
    end
    in_ir = 32'h402081B3; rs1_data = 10; rs2_data = 4;
    tick();
    checks++;
    if (out_op_ir !== 15'h2033 || out_a !== 64'd10 || out_b !== 64'd4 || out_rd !== 5'd3) begin
      failures++; $display("FAIL sub: a=%h b=%h op=%h rd=%0d required 10 4 2033 3", out_a, out_b, out_op_ir, out_rd);
    end
    in_ir = 32'h800003B7; rs1_data = 64'hDEAD;
    tick();
    checks++;
    if (out_a !== 64'd0 || out_b !== 64'hFFFF_FFFF_8000_0000) begin
      failures++; $display("FAIL lui: a=%h b=%h required 0 ffffffff80000000", out_a, out_b);
    end
    in_ir = 32'h00008293; rs1_data = 64'h11; wb_en = 1; wb_rd = 1; wb_data = 64'h55;
    tick();
    checks++;
    if (out_a !== 64'h55) begin
      failures++; $display("FAIL bypass: a=%h required 55", out_a);
    end
    in_ir = 32'h00000293; wb_rd = 0;
    tick();
    checks++;
    if (out_a !== 64'h0) begin
      failures++; $display("FAIL x0: a=%h required 0", out_a);
    end
    wb_en = 0;
    in_ir = 32'h0000007F; rs1_data = 64'h99; rs2_data = 64'h77;
    tick();
    checks++;
    if (out_illegal !== 1 || out_a !== 0 || out_b !== 0 || out_valid !== 1) begin
      failures++; $display("FAIL illegal: ill=%b a=%h b=%h v=%b required 1 0 0 1", out_illegal, out_a, out_b, out_valid);
    end
    in_ir = 32'h0062A423; rs1_data = 64'h100;
    tick();
    checks++;
    if (out_rd !== 5'd0 || out_b !== 64'd8 || out_illegal !== 0) begin
      failures++; $display("FAIL store: rd=%0d b=%h ill=%b required 0 8 0", out_rd, out_b, out_illegal);
    end
  endtask

  task automatic test_stall();
    in_valid = 1; out_ready = 1; in_ir = 32'h00A08293; rs1_data = 64'h20;
    tick();
    out_ready = 0; in_ir = 32'h402081B3; rs1_data = 64'h1; rs2_data = 64'h2;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL stall_ready: in_ready=%b required 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1 || out_a !== 64'h20 || out_b !== 64'd10 || out_op_ir !== 15'h0013 || out_rd !== 5'd5) begin
        failures++; $display("FAIL stall_hold%0d: v=%b a=%h b=%h op=%h rd=%0d", i, out_valid, out_a, out_b, out_op_ir, out_rd);
      end
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1 || out_op_ir !== 15'h2033 || out_a !== 64'h1 || out_b !== 64'h2) begin
      failures++; $display("FAIL stall_release: v=%b op=%h a=%h b=%h required 1 2033 1 2", out_valid, out_op_ir, out_a, out_b);
    end
  endtask

  task automatic test_flush();
    in_valid = 1; out_ready = 0; flush = 1; in_ir = 32'h00108113;
    tick();
    flush = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL flush: out_valid=%b required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd2) begin
      failures++; $display("FAIL post_flush: v=%b rd=%0d required 1 2", out_valid, out_rd);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1;
    tick();
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_op_ir !== 15'h0013 || out_a !== 64'd0) begin
      failures++; $display("FAIL async_reset: v=%b op=%h a=%h required 0 0013 0", out_valid, out_op_ir, out_a);
    end
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_random();
    logic [6:0] ops [14] = '{7'h33, 7'h3B, 7'h2F, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17,
                             7'h6F, 7'h63, 7'h73, 7'h7F};
    logic [31:0] ir;
    for (int i = 0; i < 400; i++) begin
      ir = $urandom;
      ir[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 13)];
      ir[19:15] = 5'($urandom_range(0, 3));
      ir[24:20] = 5'($urandom_range(0, 3));
      in_ir = ir;
      in_pc = {$urandom, $urandom};
      rs1_data = {$urandom, $urandom};
      rs2_data = {$urandom, $urandom};
      wb_en = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = {$urandom, $urandom};
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (in_ready !== (!exp_valid || out_ready) || rs1_addr !== ir[19:15] || rs2_addr !== ir[24:20]) begin
        failures++; $display("FAIL rand_comb%0d: rdy=%b rs1=%0d rs2=%0d", i, in_ready, rs1_addr, rs2_addr);
      end
      tick();
      checks++;
      if (out_valid !== exp_valid || out_a !== exp_a || out_b !== exp_b || out_op_ir !== exp_op ||
          out_rd !== exp_rd || out_illegal !== exp_ill) begin
        failures++;
        $display("FAIL rand%0d: got v=%b a=%h b=%h op=%h rd=%0d ill=%b required v=%b a=%h b=%h op=%h rd=%0d ill=%b",
                 i, out_valid, out_a, out_b, out_op_ir, out_rd, out_illegal,
                 exp_valid, exp_a, exp_b, exp_op, exp_rd, exp_ill);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
